// File: rtl/axum_arb_pkg.sv
// axum_arb_pkg: shared index-width helper and outstanding-count type for the bus arbiter.
package axum_arb_pkg;
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  typedef logic [3:0] cnt_t;
endpackage

// File: rtl/axum_bus_arbiter_if.sv
// axum_bus_arbiter_if: host-side and device-side bus signals; master is the arbiter view, slave the environment view.
interface axum_bus_arbiter_if #(
  parameter int NrHosts      = 2,
  parameter int DataWidth    = 32,
  parameter int AddressWidth = 32
);
  logic                    host_req_i    [NrHosts];
  logic                    host_gnt_o    [NrHosts];
  logic [AddressWidth-1:0] host_addr_i   [NrHosts];
  logic                    host_we_i     [NrHosts];
  logic [3:0]              host_be_i     [NrHosts];
  logic [DataWidth-1:0]    host_wdata_i  [NrHosts];
  logic                    host_rvalid_o [NrHosts];
  logic [DataWidth-1:0]    host_rdata_o  [NrHosts];
  logic                    host_err_o    [NrHosts];
  logic                    dev_req_o;
  logic                    dev_gnt_i;
  logic [AddressWidth-1:0] dev_addr_o;
  logic                    dev_we_o;
  logic [3:0]              dev_be_o;
  logic [DataWidth-1:0]    dev_wdata_o;
  logic                    dev_rvalid_i;
  logic [DataWidth-1:0]    dev_rdata_i;
  logic                    dev_err_i;
  modport master (
    input  host_req_i, host_addr_i, host_we_i, host_be_i, host_wdata_i,
           dev_gnt_i, dev_rvalid_i, dev_rdata_i, dev_err_i,
    output host_gnt_o, host_rvalid_o, host_rdata_o, host_err_o,
           dev_req_o, dev_addr_o, dev_we_o, dev_be_o, dev_wdata_o
  );
  modport slave (
    output host_req_i, host_addr_i, host_we_i, host_be_i, host_wdata_i,
           dev_gnt_i, dev_rvalid_i, dev_rdata_i, dev_err_i,
    input  host_gnt_o, host_rvalid_o, host_rdata_o, host_err_o,
           dev_req_o, dev_addr_o, dev_we_o, dev_be_o, dev_wdata_o
  );
endinterface

// File: rtl/axum_arb_id_fifo.sv
// axum_arb_id_fifo: in-order FIFO of granted host indices awaiting a device response.
module axum_arb_id_fifo
  import axum_arb_pkg::*;
#(
  parameter int Depth = 2,
  parameter int Width = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [Width-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [Width-1:0] head
);
  localparam int PW = idx_w(Depth);
  localparam logic [PW-1:0] Last = PW'(Depth - 1);
  logic [Width-1:0] mem [Depth];
  logic [PW-1:0] wp, rp;
  cnt_t cnt;
  logic do_push, do_pop;
  assign full = cnt == cnt_t'(Depth);
  assign empty = cnt == '0;
  assign head = mem[rp];
  assign do_push = push & ~full;
  assign do_pop = pop & ~empty;
  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= din;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wp <= (wp == Last) ? '0 : wp + 1'b1;
      if (do_pop) rp <= (rp == Last) ? '0 : rp + 1'b1;
      cnt <= cnt + cnt_t'(do_push) - cnt_t'(do_pop);
    end
  end
endmodule

// File: rtl/axum_bus_arbiter.sv
// axum_bus_arbiter: round-robin N-host to single-device arbiter with in-order response routing.
// Optional response watchdog enabled by defining AXUM_ARB_WATCHDOG_EN.
module axum_bus_arbiter
  import axum_arb_pkg::*;
#(
  parameter int NrHosts        = 2,
  parameter int DataWidth      = 32,
  parameter int AddressWidth   = 32,
  parameter int MaxOutstanding = 2,
  parameter int TimeoutCycles  = 255
) (
  input logic               clk_i,
  input logic               rst_i,
  axum_bus_arbiter_if.master bus
);
  localparam int IW = idx_w(NrHosts);
  logic [IW-1:0] rr_ptr, sel, head;
  logic any, full, empty, accept, pop, timeout;
  if (NrHosts < 2 || NrHosts > 8 || MaxOutstanding < 1 || MaxOutstanding > 8 || TimeoutCycles < 1) begin : g_cfg_err
    $error("axum_bus_arbiter: parameter out of range");
  end
  // Descending scan so the lowest offset from rr_ptr wins.
  always_comb begin
    sel = '0;
    any = 1'b0;
    for (int k = NrHosts - 1; k >= 0; k--) begin
      if (bus.host_req_i[(int'(rr_ptr) + k) % NrHosts]) begin
        sel = IW'((int'(rr_ptr) + k) % NrHosts);
        any = 1'b1;
      end
    end
  end
  assign bus.dev_req_o = any & ~full & ~rst_i;
  assign accept = bus.dev_req_o & bus.dev_gnt_i;
  assign bus.dev_addr_o = any ? bus.host_addr_i[sel] : {AddressWidth{1'b0}};
  assign bus.dev_we_o = any ? bus.host_we_i[sel] : 1'b0;
  assign bus.dev_be_o = any ? bus.host_be_i[sel] : 4'h0;
  assign bus.dev_wdata_o = any ? bus.host_wdata_i[sel] : {DataWidth{1'b0}};
  assign pop = ~rst_i & ~empty & (bus.dev_rvalid_i | timeout);
  always_comb begin
    for (int i = 0; i < NrHosts; i++) begin
      bus.host_gnt_o[i] = accept && sel == IW'(i);
      bus.host_rvalid_o[i] = pop && head == IW'(i);
      bus.host_err_o[i] = pop && head == IW'(i) && (bus.dev_err_i || !bus.dev_rvalid_i);
      bus.host_rdata_o[i] = timeout ? {DataWidth{1'b0}} : bus.dev_rdata_i;
    end
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) rr_ptr <= '0;
    else if (accept) rr_ptr <= (sel == IW'(NrHosts - 1)) ? '0 : sel + 1'b1;
  end
  axum_arb_id_fifo #(.Depth(MaxOutstanding), .Width(IW)) u_id_fifo (
    .clk(clk_i), .rst(rst_i), .push(accept), .pop(pop), .din(sel),
    .full(full), .empty(empty), .head(head)
  );
`ifdef AXUM_ARB_WATCHDOG_EN
  localparam int WW = $clog2(TimeoutCycles + 1);
  logic [WW-1:0] wd;
  // A real response in the expiry cycle wins over the synthetic error.
  assign timeout = ~empty & ~bus.dev_rvalid_i & (wd == WW'(TimeoutCycles));
  always_ff @(posedge clk_i) begin
    if (rst_i || empty || pop) wd <= '0;
    else wd <= wd + 1'b1;
  end
`else
  assign timeout = 1'b0;
`endif
endmodule

// File: tb/tb_axum_bus_arbiter.sv
// tb_axum_bus_arbiter: scoreboard bench for the round-robin arbiter; watchdog scenario runs when AXUM_ARB_WATCHDOG_EN is defined.
module tb_axum_bus_arbiter;
  localparam int NH = 2, MO = 2, TO = 16;
  typedef struct {int host; logic [31:0] data;} exp_t;
  typedef struct {bit r0; bit r1; bit g; bit rv; bit e;} step_t;
  logic clk = 1'b0, rst = 1'b1;
  exp_t sb[$];
  int tests = 0, fails = 0, exp_rr = 0;
  logic [31:0] haddr[2], hwdata[2], rd_val[2];
  logic hwe[2];
  always #5 clk = ~clk;
  axum_bus_arbiter_if #(.NrHosts(NH), .DataWidth(32), .AddressWidth(32)) bus ();
  axum_bus_arbiter #(.NrHosts(NH), .DataWidth(32), .AddressWidth(32), .MaxOutstanding(MO), .TimeoutCycles(TO)) dut (
    .clk_i(clk), .rst_i(rst), .bus(bus)
  );
  function automatic int pick(bit r0, bit r1);
    if (r0 && r1) return exp_rr;
    if (r0) return 0;
    if (r1) return 1;
    return -1;
  endfunction
  task automatic drive(step_t s);
    bus.host_req_i[0] = s.r0;
    bus.host_req_i[1] = s.r1;
    for (int k = 0; k < NH; k++) begin
      bus.host_addr_i[k] = haddr[k];
      bus.host_we_i[k] = hwe[k];
      bus.host_be_i[k] = 4'hF;
      bus.host_wdata_i[k] = hwdata[k];
    end
    bus.dev_gnt_i = s.g;
    bus.dev_rvalid_i = s.rv;
    bus.dev_err_i = s.e;
    bus.dev_rdata_i = (sb.size() > 0) ? sb[0].data : 32'hFFFF_FFFF;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      drive('{1, 1, 1, 1, 1});
      #1;
      tests++;
      if (bus.dev_req_o !== 1'b0 || bus.host_gnt_o[0] !== 1'b0 || bus.host_gnt_o[1] !== 1'b0) begin
        fails++;
        $display("FAIL reset_req: dev_req=%b gnt=%b%b, expected all 0", bus.dev_req_o, bus.host_gnt_o[1], bus.host_gnt_o[0]);
      end
      tests++;
      if (bus.host_rvalid_o[0] !== 1'b0 || bus.host_rvalid_o[1] !== 1'b0 || bus.host_err_o[0] !== 1'b0 || bus.host_err_o[1] !== 1'b0) begin
        fails++;
        $display("FAIL reset_rsp: rvalid=%b%b err=%b%b, expected all 0", bus.host_rvalid_o[1], bus.host_rvalid_o[0], bus.host_err_o[1], bus.host_err_o[0]);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    drive('{0, 0, 0, 0, 0});
    sb.delete();
    exp_rr = 0;
  endtask
  task automatic test_alternate();
    step_t st[7] = '{'{1, 1, 1, 0, 0}, '{1, 1, 1, 1, 0}, '{1, 1, 1, 1, 0}, '{1, 1, 1, 1, 1},
                     '{1, 1, 1, 1, 0}, '{1, 1, 1, 1, 0}, '{0, 0, 1, 1, 0}};
    int h;
    logic er;
    exp_t e;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      drive(st[i]);
      #1;
      h = pick(st[i].r0, st[i].r1);
      er = (h >= 0) && (sb.size() < MO);
      tests++;
      if (bus.dev_req_o !== er || bus.host_gnt_o[0] !== (er && st[i].g && h == 0) || bus.host_gnt_o[1] !== (er && st[i].g && h == 1)) begin
        fails++;
        $display("FAIL alt_grant step %0d: dev_req=%b gnt=%b%b, expected dev_req=%b host=%0d", i, bus.dev_req_o, bus.host_gnt_o[1], bus.host_gnt_o[0], er, h);
      end
      tests++;
      if (bus.dev_addr_o !== (h >= 0 ? haddr[h] : 32'h0)) begin
        fails++;
        $display("FAIL alt_addr step %0d: addr=%h, expected host %0d address", i, bus.dev_addr_o, h);
      end
      if (st[i].rv && sb.size() > 0) begin
        e = sb.pop_front();
        tests++;
        if (bus.host_rvalid_o[e.host] !== 1'b1 || bus.host_rvalid_o[1 - e.host] !== 1'b0 || bus.host_rdata_o[e.host] !== e.data || bus.host_rdata_o[1 - e.host] !== e.data || bus.host_err_o[e.host] !== st[i].e || bus.host_err_o[1 - e.host] !== 1'b0) begin
          fails++;
          $display("FAIL alt_rsp step %0d: rvalid=%b%b rdata=%h err=%b%b, expected host %0d data %h err %b", i, bus.host_rvalid_o[1], bus.host_rvalid_o[0], bus.host_rdata_o[e.host], bus.host_err_o[1], bus.host_err_o[0], e.host, e.data, st[i].e);
        end
      end
      if (er && st[i].g) begin
        sb.push_back('{h, hwe[h] ? 32'h0 : rd_val[h]});
        exp_rr = (h + 1) % NH;
      end
    end
  endtask
  task automatic test_full();
    step_t st[8] = '{'{1, 1, 1, 0, 0}, '{1, 1, 1, 0, 0}, '{1, 1, 1, 0, 0}, '{1, 1, 1, 0, 0},
                     '{1, 1, 1, 1, 0}, '{1, 1, 1, 0, 0}, '{0, 0, 1, 1, 0}, '{0, 0, 1, 1, 0}};
    int h;
    logic er;
    exp_t e;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      drive(st[i]);
      #1;
      h = pick(st[i].r0, st[i].r1);
      er = (h >= 0) && (sb.size() < MO);
      tests++;
      if (bus.dev_req_o !== er || bus.host_gnt_o[0] !== (er && st[i].g && h == 0) || bus.host_gnt_o[1] !== (er && st[i].g && h == 1)) begin
        fails++;
        $display("FAIL full_grant step %0d: dev_req=%b gnt=%b%b, expected dev_req=%b host=%0d", i, bus.dev_req_o, bus.host_gnt_o[1], bus.host_gnt_o[0], er, h);
      end
      if (st[i].rv && sb.size() > 0) begin
        e = sb.pop_front();
        tests++;
        if (bus.host_rvalid_o[e.host] !== 1'b1 || bus.host_rvalid_o[1 - e.host] !== 1'b0 || bus.host_rdata_o[e.host] !== e.data) begin
          fails++;
          $display("FAIL full_rsp step %0d: rvalid=%b%b rdata=%h, expected host %0d data %h", i, bus.host_rvalid_o[1], bus.host_rvalid_o[0], bus.host_rdata_o[e.host], e.host, e.data);
        end
      end
      if (er && st[i].g) begin
        sb.push_back('{h, hwe[h] ? 32'h0 : rd_val[h]});
        exp_rr = (h + 1) % NH;
      end
    end
  endtask
  task automatic test_read_after_write();
    step_t st[4] = '{'{1, 0, 1, 0, 0}, '{0, 1, 1, 0, 0}, '{0, 0, 1, 1, 0}, '{0, 0, 1, 1, 0}};
    int h;
    logic er;
    exp_t e;
    hwe[0] = 1'b1;
    hwdata[0] = 32'h1234_5678;
    rd_val[1] = 32'hDEAD_BEEF;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive(st[i]);
      #1;
      h = pick(st[i].r0, st[i].r1);
      er = (h >= 0) && (sb.size() < MO);
      tests++;
      if (bus.host_gnt_o[0] !== (er && h == 0) || bus.host_gnt_o[1] !== (er && h == 1) || bus.dev_we_o !== (h >= 0 ? hwe[h] : 1'b0) || bus.dev_wdata_o !== (h >= 0 ? hwdata[h] : 32'h0)) begin
        fails++;
        $display("FAIL raw_route step %0d: gnt=%b%b we=%b wdata=%h, expected host %0d", i, bus.host_gnt_o[1], bus.host_gnt_o[0], bus.dev_we_o, bus.dev_wdata_o, h);
      end
      if (st[i].rv && sb.size() > 0) begin
        e = sb.pop_front();
        tests++;
        if (bus.host_rvalid_o[e.host] !== 1'b1 || bus.host_rvalid_o[1 - e.host] !== 1'b0 || bus.host_rdata_o[e.host] !== e.data) begin
          fails++;
          $display("FAIL raw_rsp step %0d: rvalid=%b%b rdata=%h, expected host %0d data %h", i, bus.host_rvalid_o[1], bus.host_rvalid_o[0], bus.host_rdata_o[e.host], e.host, e.data);
        end
      end
      if (er && st[i].g) begin
        sb.push_back('{h, hwe[h] ? 32'h0 : rd_val[h]});
        exp_rr = (h + 1) % NH;
      end
    end
    hwe[0] = 1'b0;
  endtask
  task automatic test_stall();
    step_t st[7] = '{'{1, 1, 0, 0, 0}, '{1, 1, 0, 0, 0}, '{1, 1, 0, 0, 0}, '{1, 1, 0, 0, 0},
                     '{1, 1, 0, 0, 0}, '{1, 1, 1, 0, 0}, '{0, 0, 1, 1, 0}};
    int h;
    logic er;
    exp_t e;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      drive(st[i]);
      #1;
      h = pick(st[i].r0, st[i].r1);
      er = (h >= 0) && (sb.size() < MO);
      tests++;
      if (bus.dev_req_o !== er || bus.host_gnt_o[0] !== (er && st[i].g && h == 0) || bus.host_gnt_o[1] !== (er && st[i].g && h == 1) || bus.dev_addr_o !== (h >= 0 ? haddr[h] : 32'h0)) begin
        fails++;
        $display("FAIL stall step %0d: dev_req=%b gnt=%b%b addr=%h, expected host %0d gnt_i=%b", i, bus.dev_req_o, bus.host_gnt_o[1], bus.host_gnt_o[0], bus.dev_addr_o, h, st[i].g);
      end
      if (st[i].rv && sb.size() > 0) begin
        e = sb.pop_front();
        tests++;
        if (bus.host_rvalid_o[e.host] !== 1'b1 || bus.host_rdata_o[e.host] !== e.data) begin
          fails++;
          $display("FAIL stall_rsp step %0d: rvalid=%b%b rdata=%h, expected host %0d data %h", i, bus.host_rvalid_o[1], bus.host_rvalid_o[0], bus.host_rdata_o[e.host], e.host, e.data);
        end
      end
      if (er && st[i].g) begin
        sb.push_back('{h, hwe[h] ? 32'h0 : rd_val[h]});
        exp_rr = (h + 1) % NH;
      end
    end
  endtask
  task automatic test_reset_mid();
    @(negedge clk);
    drive('{0, 1, 1, 0, 0});
    @(negedge clk);
    drive('{1, 0, 1, 0, 0});
    @(negedge clk);
    rst = 1'b1;
    drive('{1, 1, 1, 1, 0});
    #1;
    tests++;
    if (bus.dev_req_o !== 1'b0 || bus.host_gnt_o[0] !== 1'b0 || bus.host_gnt_o[1] !== 1'b0 || bus.host_rvalid_o[0] !== 1'b0 || bus.host_rvalid_o[1] !== 1'b0) begin
      fails++;
      $display("FAIL midreset_out: dev_req=%b gnt=%b%b rvalid=%b%b, expected all 0", bus.dev_req_o, bus.host_gnt_o[1], bus.host_gnt_o[0], bus.host_rvalid_o[1], bus.host_rvalid_o[0]);
    end
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    exp_rr = 0;
    drive('{0, 0, 1, 1, 0});
    #1;
    tests++;
    if (bus.host_rvalid_o[0] !== 1'b0 || bus.host_rvalid_o[1] !== 1'b0 || bus.host_err_o[0] !== 1'b0 || bus.host_err_o[1] !== 1'b0) begin
      fails++;
      $display("FAIL stray_rvalid: rvalid=%b%b err=%b%b, expected all 0", bus.host_rvalid_o[1], bus.host_rvalid_o[0], bus.host_err_o[1], bus.host_err_o[0]);
    end
    @(negedge clk);
    drive('{1, 1, 1, 0, 0});
    #1;
    tests++;
    if (bus.host_gnt_o[0] !== 1'b1 || bus.host_gnt_o[1] !== 1'b0) begin
      fails++;
      $display("FAIL post_reset_grant: gnt=%b%b, expected 01", bus.host_gnt_o[1], bus.host_gnt_o[0]);
    end
    sb.push_back('{0, rd_val[0]});
    exp_rr = 1;
    @(negedge clk);
    drive('{0, 0, 1, 1, 0});
    #1;
    tests++;
    if (bus.host_rvalid_o[0] !== 1'b1 || bus.host_rdata_o[0] !== sb[0].data) begin
      fails++;
      $display("FAIL post_reset_rsp: rvalid=%b%b rdata=%h, expected host 0 data %h", bus.host_rvalid_o[1], bus.host_rvalid_o[0], bus.host_rdata_o[0], sb[0].data);
    end
    void'(sb.pop_front());
  endtask
`ifdef AXUM_ARB_WATCHDOG_EN
  task automatic test_watchdog();
    int seen;
    for (int pass = 0; pass < 2; pass++) begin
      @(negedge clk);
      drive('{1, 0, 1, 0, 0});
      #1;
      tests++;
      if (bus.host_gnt_o[0] !== 1'b1) begin
        fails++;
        $display("FAIL wd_grant pass %0d: gnt0=%b, expected 1", pass, bus.host_gnt_o[0]);
      end
      seen = 0;
      for (int k = 1; k <= 40 && seen == 0; k++) begin
        @(negedge clk);
        drive('{0, 0, 0, (pass == 1 && k == TO + 1), 0});
        bus.dev_rdata_i = 32'hCAFE_F00D;
        #1;
        if (bus.host_rvalid_o[0] === 1'b1) begin
          seen = k;
          tests++;
          if (k != TO + 1 || bus.host_err_o[0] !== (pass == 0) || bus.host_rdata_o[0] !== (pass == 0 ? 32'h0 : 32'hCAFE_F00D)) begin
            fails++;
            $display("FAIL wd_rsp pass %0d: cycle=%0d err=%b rdata=%h, expected cycle %0d err %b", pass, k, bus.host_err_o[0], bus.host_rdata_o[0], TO + 1, pass == 0);
          end
        end
      end
      if (seen == 0) begin
        tests++;
        fails++;
        $display("FAIL wd_expire pass %0d: no host_rvalid within 40 cycles, expected at %0d", pass, TO + 1);
      end
    end
    exp_rr = 1;
    @(negedge clk);
    drive('{0, 0, 0, 0, 0});
  endtask
`endif
  initial begin
    haddr[0] = 32'h0000_0100;
    haddr[1] = 32'h0000_0200;
    hwdata[0] = 32'h0;
    hwdata[1] = 32'h5555_AAAA;
    hwe[0] = 1'b0;
    hwe[1] = 1'b0;
    rd_val[0] = 32'hA0A0_0000;
    rd_val[1] = 32'hB1B1_1111;
    test_reset();
    test_alternate();
    test_full();
    test_read_after_write();
    test_stall();
    test_reset_mid();
`ifdef AXUM_ARB_WATCHDOG_EN
    test_watchdog();
`endif
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/axum_bus_arbiter.md
AXUM_BUS_ARBITER -- requirements
Module: axum_bus_arbiter

Interface
REQ-001 SHALL have parameter NrHosts, default 2, number of requesting hosts (2..8).
REQ-002 SHALL have parameter DataWidth, default 32, data bus width.
REQ-003 SHALL have parameter AddressWidth, default 32, address bus width.
REQ-004 SHALL have parameter MaxOutstanding, default 2, accepted-but-unanswered transactions held (1..8).
REQ-005 SHALL have parameter TimeoutCycles, default 255, watchdog limit in cycles.
REQ-006 SHALL use one clock and a synchronous, active-high reset.
REQ-007 SHALL have port: clk_i  input  1  system clock, all logic on rising edge.
REQ-008 SHALL have port: rst_i  input  1  synchronous reset, active-high.
REQ-009 SHALL have ports (unpacked arrays [NrHosts]): host_req_i in 1; host_gnt_o out 1; host_addr_i in AddressWidth; host_we_i in 1; host_be_i in 4; host_wdata_i in DataWidth; host_rvalid_o out 1; host_rdata_o out DataWidth; host_err_o out 1.
REQ-010 SHALL have device ports: dev_req_o out 1; dev_gnt_i in 1; dev_addr_o out AddressWidth; dev_we_o out 1; dev_be_o out 4; dev_wdata_o out DataWidth; dev_rvalid_i in 1; dev_rdata_i in DataWidth; dev_err_i in 1.

Function
REQ-011 SHALL select host sel = first asserted host_req_i searching upward from rr_ptr, wrapping NrHosts-1 -> 0.
REQ-012 SHALL drive dev_req_o = (any host_req_i) & ~id_full, combinationally.
REQ-013 SHALL route sel's addr/we/be/wdata to dev_*_o; SHALL drive dev_*_o (except dev_req_o) to 0 when no host requests.
REQ-014 SHALL assert host_gnt_o[sel] = dev_req_o & dev_gnt_i, same cycle; all other host_gnt_o SHALL be 0.
REQ-015 On accept (dev_req_o & dev_gnt_i) SHALL push sel into an in-order ID FIFO and set rr_ptr = (sel+1) mod NrHosts.
REQ-016 SHALL NOT change rr_ptr when no accept occurs; a waiting host SHALL wait at most NrHosts-1 accepts.
REQ-017 On dev_rvalid_i with FIFO non-empty SHALL assert host_rvalid_o[head] for one cycle and pop head; latency device->host 0 cycles.
REQ-018 SHALL broadcast dev_rdata_i to every host_rdata_o; host_err_o[head] = dev_err_i when rvalid, else 0.
REQ-019 SHALL ignore dev_rvalid_i when FIFO empty (no host_rvalid_o, no state change).
REQ-020 Full: id_full = (count == MaxOutstanding), registered count; no grant while full even if a pop occurs that cycle.
REQ-021 Simultaneous push and pop (not full) SHALL leave count unchanged and preserve order.

Reset
REQ-022 While rst_i=1: FIFO empty, count 0, rr_ptr 0, watchdog 0; dev_req_o, all host_gnt_o, host_rvalid_o, host_err_o SHALL be 0.
REQ-023 Reset mid-transaction SHALL discard outstanding IDs; responses arriving after reset release SHALL be dropped per REQ-019.

Configuration
REQ-024 Macro AXUM_ARB_WATCHDOG_EN defined: counter increments each cycle FIFO non-empty without dev_rvalid_i, clears on any pop or when empty.
REQ-025 With AXUM_ARB_WATCHDOG_EN, when counter reaches TimeoutCycles SHALL emit host_rvalid_o[head]=1, host_err_o[head]=1, host_rdata_o=0, pop head, clear counter; dev_rvalid_i in same cycle takes precedence (normal response, no error).
REQ-026 Without AXUM_ARB_WATCHDOG_EN: no counter logic; arbiter waits indefinitely for dev_rvalid_i.

Structure
REQ-027 Package axum_arb_pkg SHALL hold host-index width function (clog2, min 1) and typedef of FIFO count.
REQ-028 ID FIFO SHALL be sub-module axum_arb_id_fifo (depth MaxOutstanding, push/pop/full/empty/head).

Verification
REQ-029 Hosts 0,1 request continuously, dev_gnt_i=1, 1-cycle rvalid -> grants alternate 0,1,0,1; rvalid returns to matching host.
REQ-030 MaxOutstanding=2, dev_rvalid_i held 0 -> 2 grants, then dev_req_o=0 until first rvalid; next grant cycle after pop.
REQ-031 Host 1 reads 0xDEADBEEF while host 0 write pending -> host_rvalid_o[0] first, then host_rvalid_o[1] with rdata 0xDEADBEEF.
REQ-032 dev_gnt_i=0 for 5 cycles -> host_gnt_o all 0, rr_ptr unchanged, dev_addr_o stable.
REQ-033 AXUM_ARB_WATCHDOG_EN, TimeoutCycles=16, no rvalid -> cycle 16 host_rvalid_o[head]=1, host_err_o=1, rdata 0.
REQ-034 rst_i asserted with 2 outstanding, then stray dev_rvalid_i -> no host_rvalid_o; first post-reset grant to host 0.
